cluster_ctrl: RTL and testbench

Parametrised run controller for the multi-core multiplier cluster. It launches NUM_CORES cores in lockstep from a common instruction stream and resets them first. It then watches the per-core halt flags and reports completion with a cycle count and a timeout flag. It also captures the broadcast instruction stream into a trace FIFO for host read-back. The block sits between the host/test harness and the core array, and replaces the single registered instruction tap with a bounded trace buffer plus a run/done handshake.

---
 rtl/cluster_pkg.sv | 20 ++
 rtl/cluster_ctrl_trace_fifo.sv | 59 +++++
 rtl/cluster_ctrl.sv | 125 ++++++++++++
 tb/tb_cluster_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// cluster_pkg: shared state encoding and helpers
// for the multiplier-cluster run controller.
package cluster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/cluster_ctrl_trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO that
// drops pushes on full and flags it stickily.
module trace_fifo
  import cluster_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // pointers and overflow flag; flush restarts the trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // storage; contents are only visible through
  // the pointers, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cluster_ctrl.sv
// cluster_ctrl: lockstep launch, halt watch and
// instruction trace for the multiplier cluster.
module cluster_ctrl
  import cluster_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int INSTR_W     = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int CYC_W       = 16,
  parameter int RST_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_halt,
  input  logic [INSTR_W-1:0]   im_instr,
  input  logic                 im_valid,
  output logic                 core_rst,
  output logic [NUM_CORES-1:0] core_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CYC_W-1:0]     cycle_count,
  input  logic                 trace_rd,
  output logic [INSTR_W-1:0]   trace_data,
  output logic                 trace_empty,
  output logic                 trace_ovf
);

  localparam int RW = clog2(RST_CYCLES) + 1;
  localparam logic [RW-1:0] RST_LAST =
    RW'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] CNT_LAST =
    {{(CYC_W-1){1'b1}}, 1'b0};

  state_t               state_q;
  state_t               state_d;
  logic [NUM_CORES-1:0] mask_q;
  logic [RW-1:0]        rst_cnt;
  logic                 launch;
  logic                 all_halt;
  logic                 push;

  assign launch   = start && (state_q == ST_IDLE ||
                              state_q == ST_DONE);
  assign all_halt = (core_halt & mask_q) == mask_q;
  assign push     = (state_q == ST_RUN) && im_valid;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state and per-state core controls
  always_comb begin
    state_d  = state_q;
    core_rst = 1'b0;
    core_en  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        core_rst = 1'b1;
        busy     = 1'b1;
        if (rst_cnt == RST_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_en = mask_q;
        busy    = 1'b1;
        if (all_halt || cycle_count == CNT_LAST)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mask latch, reset-hold counter, run counter;
  // the counter stops one short of wrapping and
  // flags the timeout on that same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q      <= '0;
      rst_cnt     <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else if (launch) begin
      mask_q      <= core_mask;
      rst_cnt     <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR)
        rst_cnt <= rst_cnt + RW'(1);
      if (state_q == ST_RUN && !all_halt) begin
        cycle_count <= cycle_count + CYC_W'(1);
        if (cycle_count == CNT_LAST) timeout <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .rst   (rst),
    .flush (launch),
    .push  (push),
    .pop   (trace_rd),
    .din   (im_instr),
    .dout  (trace_data),
    .empty (trace_empty),
    .ovf   (trace_ovf)
  );

endmodule

// File: tb/tb_cluster_ctrl.sv
// tb_cluster_ctrl: randomized run/trace stimulus
// checked against a run-level reference model.
module tb_cluster_ctrl;

  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int RC    = 2;
  localparam int NEV   = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_to;
  logic [3:0] core_mask;
  logic [3:0] core_halt;
  logic [7:0] im_instr;
  logic       im_valid;
  logic       im_valid_to;
  logic       trace_rd;

  logic        core_rst;
  logic [3:0]  core_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;
  logic [7:0]  trace_data;
  logic        trace_empty;
  logic        trace_ovf;

  logic       to_core_rst;
  logic [3:0] to_core_en;
  logic       to_busy;
  logic       to_done;
  logic       to_timeout;
  logic [3:0] to_cycle_count;
  logic [7:0] to_trace_data;
  logic       to_trace_empty;
  logic       to_trace_ovf;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_run;
  bit         m_flush;
  int         ht[4];
  int         n_chk;
  int         n_pass;

  always #5 clk = ~clk;

  cluster_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_mask   (core_mask),
    .core_halt   (core_halt),
    .im_instr    (im_instr),
    .im_valid    (im_valid),
    .core_rst    (core_rst),
    .core_en     (core_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .trace_empty (trace_empty),
    .trace_ovf   (trace_ovf)
  );

  cluster_ctrl #(.CYC_W(4)) u_to (
    .clk         (clk),
    .rst         (rst),
    .start       (start_to),
    .core_mask   (core_mask),
    .core_halt   (core_halt),
    .im_instr    (im_instr),
    .im_valid    (im_valid_to),
    .core_rst    (to_core_rst),
    .core_en     (to_core_en),
    .busy        (to_busy),
    .done        (to_done),
    .timeout     (to_timeout),
    .cycle_count (to_cycle_count),
    .trace_rd    (trace_rd),
    .trace_data  (to_trace_data),
    .trace_empty (to_trace_empty),
    .trace_ovf   (to_trace_ovf)
  );

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  // one clock: update the trace model with the
  // inputs seen at the edge, return at negedge
  task automatic tick();
    bit pop_ok;
    bit push_ok;
    @(posedge clk);
    if (m_flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop_ok  = trace_rd && q.size() > 0;
      push_ok = m_run && im_valid &&
                (q.size() < DEPTH || pop_ok);
      if (m_run && im_valid && !push_ok) m_ovf = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(im_instr);
    end
    @(negedge clk);
  endtask

  task automatic check_trace();
    check("trace_empty", trace_empty, q.size() == 0);
    check("trace_data", trace_data,
          q.size() > 0 ? q[0] : 8'h00);
    check("trace_ovf", trace_ovf, m_ovf);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_core_rst"}, core_rst, 0);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_count"}, cycle_count, 0);
    check({tag, "_empty"}, trace_empty, 1);
    check({tag, "_ovf"}, trace_ovf, 0);
    check({tag, "_tdata"}, trace_data, 0);
  endtask

  task automatic drive(int vmode, int rdmode, int i);
    if (vmode == 0) begin
      im_valid = 1'($urandom);
      im_instr = 8'($urandom);
      start    = ($urandom_range(0, 7) == 0);
    end else begin
      im_valid = (i >= 0 && i < 20);
      im_instr = 8'(i + 1);
    end
    case (rdmode)
      0: trace_rd = 1'b0;
      1: trace_rd = 1'b1;
      default: trace_rd = 1'($urandom);
    endcase
  endtask

  // full run: launch, reset hold, run until the
  // masked halts all read high or the counter tops
  task automatic run(logic [3:0] m,
                     int vmode, int rdmode);
    int         i;
    bit         all;
    bit         to;
    logic [3:0] h;
    int         exp_cnt;
    core_mask = m;
    core_halt = '0;
    start     = 1'b1;
    m_flush   = 1'b1;
    tick();
    m_flush   = 1'b0;
    start     = 1'b0;
    core_mask = 4'($urandom);
    for (int c = 0; c < RC; c++) begin
      check("clr_core_rst", core_rst, 1);
      check("clr_core_en", core_en, 0);
      check("clr_busy", busy, 1);
      check("clr_done", done, 0);
      drive(vmode, rdmode, -1);
      tick();
      check_trace();
    end
    i   = 0;
    all = 1'b0;
    to  = 1'b0;
    forever begin
      h = '0;
      for (int c = 0; c < NC; c++)
        if (ht[c] <= i) h[c] = 1'b1;
      core_halt = (h & m) | (4'($urandom) & ~m);
      drive(vmode, rdmode, i);
      check("run_core_en", core_en, m);
      check("run_core_rst", core_rst, 0);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_count", cycle_count, i);
      all = (h & m) == m;
      to  = !all && (i + 1 == 2**CW - 1);
      m_run = 1'b1;
      tick();
      m_run = 1'b0;
      check_trace();
      if (all || to) break;
      i++;
      if (i > 5000) begin
        n_chk++;
        $display("FAIL run_bound: no done after %0d", i);
        break;
      end
    end
    start    = 1'b0;
    im_valid = 1'b0;
    trace_rd = 1'b0;
    exp_cnt  = all ? i : 2**CW - 1;
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_core_en", core_en, 0);
    check("end_core_rst", core_rst, 0);
    check("end_count", cycle_count, exp_cnt);
    check("end_timeout", timeout, to);
  endtask

  task automatic drain();
    int k;
    k = 0;
    trace_rd = 1'b1;
    while (q.size() > 0 && k < DEPTH + 2) begin
      tick();
      check_trace();
      k++;
    end
    trace_rd = 1'b0;
    check("drain_empty", trace_empty, 1);
  endtask

  initial begin
    int n;
    n_chk = 0; n_pass = 0;
    m_ovf = 0; m_run = 0; m_flush = 0;
    rst = 1'b1; start = 1'b1; start_to = 1'b1;
    core_mask = 4'hF; core_halt = '0;
    im_instr = '0; im_valid = 1'b0;
    im_valid_to = 1'b0; trace_rd = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    check("rst_to_busy", to_busy, 0);
    rst = 1'b0; start = 1'b0; start_to = 1'b0;
    tick();
    tick();
    check_reset("idle");

    ht = '{3, 5, 7, 9};
    run(4'b1111, 0, 2);
    check("all4_count", cycle_count, 9);
    drain();

    ht = '{4, NEV, 4, NEV};
    run(4'b0101, 0, 2);
    check("m0101_count", cycle_count, 4);
    check("m0101_to", timeout, 0);
    drain();

    ht = '{NEV, NEV, NEV, NEV};
    run(4'b0000, 0, 2);
    check("zero_count", cycle_count, 0);
    drain();

    core_mask = 4'hF;
    core_halt = '0;
    start_to  = 1'b1;
    tick();
    start_to  = 1'b0;
    n = 1;
    while (!to_done && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", n, 1 + RC + 15);
    check("to_timeout", to_timeout, 1);
    check("to_count", to_cycle_count, 15);
    check("to_core_en", to_core_en, 0);
    check("to_busy", to_busy, 0);
    check("to_core_rst", to_core_rst, 0);
    check("to_empty", to_trace_empty, 1);
    check("to_ovf", to_trace_ovf, 0);
    check("to_tdata", to_trace_data, 0);

    ht = '{20, 20, 20, 20};
    run(4'b1111, 1, 0);
    check("fill_ovf", trace_ovf, 1);
    trace_rd = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      check("fill_read", trace_data, j);
      tick();
    end
    trace_rd = 1'b0;
    check("fill_empty", trace_empty, 1);
    check_trace();

    run(4'b1111, 1, 1);
    check("stream_ovf", trace_ovf, 0);
    check("stream_empty", trace_empty, 1);

    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < NC; c++)
        ht[c] = $urandom_range(0, 30);
      run(4'($urandom), 0, 2);
      if (r[0]) drain();
    end
    drain();

    core_mask = 4'b1111;
    core_halt = '0;
    start     = 1'b1;
    m_flush   = 1'b1;
    tick();
    m_flush   = 1'b0;
    start     = 1'b0;
    im_valid  = 1'b1;
    im_instr  = 8'hAA;
    repeat (RC) tick();
    m_run = 1'b1;
    repeat (3) tick();
    m_run = 1'b0;
    check("mid_busy", busy, 1);
    check("mid_core_en", core_en, 4'b1111);
    check_trace();
    rst = 1'b1;
    #1;
    check_reset("midrst");
    q.delete();
    m_ovf    = 1'b0;
    im_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_reset("postrst");
    ht = '{2, 2, 2, 2};
    run(4'b1111, 0, 2);
    check("rerun_count", cycle_count, 2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
